accum_bin_ram: RTL and testbench

Parametrised simple-dual-port spectrum bin memory with an in-place read-modify-write accumulate mode, a hardware clear sweep and a registered read port with collision forwarding. It replaces the fixed 4-bit × 8-word unit RAM in the spectrometer's shared-memory path. The FFT magnitude stage accumulates power per bin here, and the readout/UART path drains bins through the read port.

---
 rtl/accum_bin_ram.sv | 148 ++++++++++++++
 tb/tb_accum_bin_ram.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/accum_bin_ram.sv
// Spectrum bin memory: overwrite/accumulate writes, clear sweep,
// registered read port with collision forwarding.
module accum_bin_ram #(
   parameter int word_width    = 16,
   parameter int address_width = 10
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_clear_start,
   output logic                     o_busy,
   input  logic                     i_wr_en,
   input  logic                     i_acc_en,
   input  logic [address_width-1:0] i_wr_address,
   input  logic [word_width-1:0]    i_wr_data,
   input  logic                     i_rd_en,
   input  logic [address_width-1:0] i_rd_address,
   output logic [word_width-1:0]    o_rd_data,
   output logic                     o_rd_valid,
   output logic                     o_sat_flag
);

   localparam int DEPTH = 2 ** address_width;

   typedef enum logic {
      ST_IDLE,
      ST_CLEAR
   } state_t;

   state_t                   r_state;
   state_t                   w_next;
   logic                     w_accept;
   logic                     w_sweep;
   logic                     w_last;
   logic [address_width-1:0] r_clr_addr;

   logic                     r_pend_vld;
   logic                     r_pend_acc;
   logic [address_width-1:0] r_pend_addr;
   logic [word_width-1:0]    r_pend_data;
   logic [word_width-1:0]    r_pend_old;

   logic [word_width-1:0]    r_mem [DEPTH];

   logic                     w_take;
   logic [word_width:0]      w_sum;
   logic                     w_carry;
   logic                     w_sat;
   logic [word_width-1:0]    w_commit_val;
   logic [word_width-1:0]    w_wr_old;
   logic [word_width-1:0]    w_rd_val;

   assign w_sweep = (r_state == ST_CLEAR);
   assign w_last  = (r_clr_addr == {address_width{1'b1}});
   assign o_busy  = w_sweep;
   assign w_take  = i_wr_en && !w_sweep;

   assign w_sum   = {1'b0, r_pend_old} + {1'b0, r_pend_data};
   assign w_carry = w_sum[word_width];
   assign w_sat   = r_pend_vld && r_pend_acc && w_carry;

   assign w_commit_val = !r_pend_acc ? r_pend_data :
                         w_carry     ? {word_width{1'b1}} :
                                       w_sum[word_width-1:0];

   // Old value for a new command: forward the commit landing this edge.
   assign w_wr_old = (r_pend_vld && r_pend_addr == i_wr_address) ?
                     w_commit_val : r_mem[i_wr_address];

   // Read result: sweep zero first, then pending commit, then memory.
   assign w_rd_val = (w_sweep && r_clr_addr == i_rd_address) ?
                     '0 :
                     (r_pend_vld && r_pend_addr == i_rd_address) ?
                     w_commit_val : r_mem[i_rd_address];

   // Clear FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   // Clear FSM next state and accept strobe.
   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (i_clear_start) begin
               w_next   = ST_CLEAR;
               w_accept = 1'b1;
            end
         end
         ST_CLEAR: begin
            if (w_last) w_next = ST_IDLE;
         end
      endcase
   end

   // Sweep address counter; holds at the top address.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 r_clr_addr <= '0;
      else if (w_accept)          r_clr_addr <= '0;
      else if (w_sweep && !w_last) r_clr_addr <= r_clr_addr + 1'b1;
   end

   // Single pending write command with its launched old value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend_vld  <= 1'b0;
         r_pend_acc  <= 1'b0;
         r_pend_addr <= '0;
         r_pend_data <= '0;
         r_pend_old  <= '0;
      end else begin
         r_pend_vld <= w_take;
         if (w_take) begin
            r_pend_acc  <= i_acc_en;
            r_pend_addr <= i_wr_address;
            r_pend_data <= i_wr_data;
            r_pend_old  <= w_wr_old;
         end
      end
   end

   // Memory array: commit first, sweep zero overrides on same bin.
   always_ff @(posedge clk) begin
      if (r_pend_vld) r_mem[r_pend_addr] <= w_commit_val;
      if (w_sweep)    r_mem[r_clr_addr]  <= '0;
   end

   // Registered read port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_rd_valid <= 1'b0;
         o_rd_data  <= '0;
      end else begin
         o_rd_valid <= i_rd_en;
         if (i_rd_en) o_rd_data <= w_rd_val;
      end
   end

   // Sticky saturation flag, cleared by an accepted clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        o_sat_flag <= 1'b0;
      else if (w_accept) o_sat_flag <= 1'b0;
      else if (w_sat)    o_sat_flag <= 1'b1;
   end

endmodule

// File: tb/tb_accum_bin_ram.sv
// Directed bench for accum_bin_ram (16-bit words, 16 bins).
// Checks clear sweep, forwarding, accumulate, saturation, reset.
module tb_accum_bin_ram;

   localparam int WW = 16;
   localparam int AW = 4;

   logic          clk;
   logic          rst_n;
   logic          clear_start;
   logic          busy;
   logic          wr_en;
   logic          acc_en;
   logic [AW-1:0] wr_address;
   logic [WW-1:0] wr_data;
   logic          rd_en;
   logic [AW-1:0] rd_address;
   logic [WW-1:0] rd_data;
   logic          rd_valid;
   logic          sat_flag;

   int errors = 0;
   int checks = 0;
   int n;

   accum_bin_ram #(
      .word_width   (WW),
      .address_width(AW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_clear_start(clear_start),
      .o_busy       (busy),
      .i_wr_en      (wr_en),
      .i_acc_en     (acc_en),
      .i_wr_address (wr_address),
      .i_wr_data    (wr_data),
      .i_rd_en      (rd_en),
      .i_rd_address (rd_address),
      .o_rd_data    (rd_data),
      .o_rd_valid   (rd_valid),
      .o_sat_flag   (sat_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic acc, input logic [AW-1:0] a,
                     input logic [WW-1:0] d);
      wr_en      = 1'b1;
      acc_en     = acc;
      wr_address = a;
      wr_data    = d;
      step();
      wr_en      = 1'b0;
   endtask

   task automatic rd(input logic [AW-1:0] a, input logic [WW-1:0] exp,
                     input string tag);
      rd_en      = 1'b1;
      rd_address = a;
      step();
      rd_en      = 1'b0;
      chk({tag, "_valid"}, {31'd0, rd_valid}, 32'd1);
      chk({tag, "_data"}, {16'd0, rd_data}, {16'd0, exp});
   endtask

   initial begin
      rst_n       = 1'b0;
      clear_start = 1'b0;
      wr_en       = 1'b0;
      acc_en      = 1'b0;
      wr_address  = '0;
      wr_data     = '0;
      rd_en       = 1'b0;
      rd_address  = '0;
      #12;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
      chk("rst_rd_data", {16'd0, rd_data}, 32'd0);
      chk("rst_sat", {31'd0, sat_flag}, 32'd0);
      rst_n = 1'b1;
      step();

      // First clear sweep: busy exactly 16 cycles.
      clear_start = 1'b1;
      step();
      clear_start = 1'b0;
      n = 0;
      while (busy && n < 40) begin
         step();
         n++;
      end
      chk("sweep1_len", n, 32'd16);

      for (int i = 0; i < 16; i++) rd(AW'(i), 16'h0000, "clr_rd");
      step();
      chk("rd_valid_drop", {31'd0, rd_valid}, 32'd0);
      chk("rd_data_hold", {16'd0, rd_data}, 32'd0);

      // Overwrite then read next cycle (forwarded).
      wr(1'b0, 4'd5, 16'h1234);
      rd(4'd5, 16'h1234, "ovw_fwd");

      // Back-to-back accumulate to bin 7.
      wr_en = 1'b1; acc_en = 1'b1; wr_address = 4'd7;
      wr_data = 16'd3; step();
      wr_data = 16'd4; step();
      wr_data = 16'd5; step();
      wr_en = 1'b0;
      rd(4'd7, 16'd12, "acc_sum");
      chk("acc_no_sat", {31'd0, sat_flag}, 32'd0);

      // Same-edge read and write returns old value.
      wr_en = 1'b1; acc_en = 1'b0; wr_address = 4'd7;
      wr_data = 16'h0055;
      rd(4'd7, 16'd12, "rdw_old");
      rd(4'd7, 16'h0055, "rdw_new");

      // Exact fill to all-ones without carry.
      wr(1'b0, 4'd3, 16'hFFFE);
      wr(1'b1, 4'd3, 16'h0001);
      rd(4'd3, 16'hFFFF, "fill_ffff");
      chk("fill_no_sat", {31'd0, sat_flag}, 32'd0);

      // Saturating accumulate.
      wr(1'b0, 4'd2, 16'hFFF0);
      wr(1'b1, 4'd2, 16'h0020);
      rd(4'd2, 16'hFFFF, "sat_val");
      chk("sat_set", {31'd0, sat_flag}, 32'd1);
      wr(1'b1, 4'd4, 16'h0001);
      rd(4'd4, 16'h0001, "sat_other");
      chk("sat_sticky", {31'd0, sat_flag}, 32'd1);

      // Sweep with writes and a second clear_start during busy.
      clear_start = 1'b1;
      step();
      clear_start = 1'b0;
      chk("sat_cleared", {31'd0, sat_flag}, 32'd0);
      chk("busy_rise", {31'd0, busy}, 32'd1);
      n = 0;
      while (busy && n < 40) begin
         wr_en       = 1'b1;
         acc_en      = 1'b0;
         wr_address  = 4'd0;
         wr_data     = 16'hABCD;
         clear_start = (n == 3);
         step();
         n++;
      end
      wr_en       = 1'b0;
      clear_start = 1'b0;
      chk("sweep2_len", n, 32'd16);
      step();
      rd(4'd0, 16'h0000, "busy_drop");
      rd(4'd7, 16'h0000, "sweep2_b7");
      chk("sat_after_sweep", {31'd0, sat_flag}, 32'd0);

      // Populate, then clear with a same-edge pending write.
      wr(1'b0, 4'd2, 16'h2222);
      wr(1'b0, 4'd12, 16'hC0C0);
      step();
      clear_start = 1'b1;
      wr_en       = 1'b1;
      acc_en      = 1'b0;
      wr_address  = 4'd9;
      wr_data     = 16'h0999;
      step();
      clear_start = 1'b0;
      wr_en       = 1'b0;
      chk("busy_rise2", {31'd0, busy}, 32'd1);
      rd(4'd9, 16'h0999, "pend_fwd");
      rd(4'd9, 16'h0999, "pend_mem");
      step();
      step();
      step();

      // Reset mid-sweep: busy drops at once, unswept bins kept.
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_valid", {31'd0, rd_valid}, 32'd0);
      chk("midrst_data", {16'd0, rd_data}, 32'd0);
      step();
      step();
      rst_n = 1'b1;
      step();
      chk("post_rst_busy", {31'd0, busy}, 32'd0);
      rd(4'd9, 16'h0999, "unswept_b9");
      rd(4'd12, 16'hC0C0, "unswept_b12");
      rd(4'd2, 16'h0000, "swept_b2");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
